ether_rx_driver: RTL and testbench
==================================

ETHER_RX_DRIVER -- requirements
Module: ether_rx_driver

Interface
REQ-001 SHALL have parameter ETH_MAX_FRAME_SIZE, default 256, the frame buffer width in bits; must be a multiple of 8 and at least 128.
REQ-002 SHALL have ports: clk  in  1  single clock; MII RX signals are sampled on its rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports: mii_rxd  in  4  received nibble.
REQ-005 SHALL have ports: mii_rx_dv  in  1  receive data valid.
REQ-006 SHALL have ports: mii_rx_err  in  1  PHY receive error.
REQ-007 SHALL have ports: rx_drv_rd_data  out  ETH_MAX_FRAME_SIZE  received frame, first nibble MSB-aligned.
REQ-008 SHALL have ports: rx_drv_rd_len  out  clog2(ETH_MAX_FRAME_SIZE/4)+1  count of stored nibbles.
REQ-009 SHALL have ports: rx_drv_rd_valid  out  1 and rx_drv_rd_ready  in  1  frame handshake.
REQ-010 SHALL have ports: rx_err_status  out  5  sticky error bits {busy, len, type, mii, preamble} (MSB to LSB).
REQ-011 SHALL have ports: rx_err_clr  in  1  pulse that clears rx_err_status.
REQ-012 SHALL have ports: rx_drop_count  out  8  count of dropped frames, saturating at 255.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, RECEIVE, HOLD and DROP.
REQ-014 SHALL register mii_rx_dv into dv_q; IDLE SHALL go to PREAMBLE only when mii_rx_dv=1 and dv_q=0 (rising edge).
REQ-015 SHALL treat 4'b1010 as a preamble nibble and 4'b1011 as SFD; in PREAMBLE, SFD seen after at least one preamble nibble SHALL go to RECEIVE with nibble count 0.
REQ-016 SHALL, in PREAMBLE, treat any other nibble, SFD as the first nibble, or mii_rx_dv falling before SFD as a preamble error: go to DROP.
REQ-017 SHALL strip preamble and SFD; nibble k after SFD SHALL be stored at bits [ETH_MAX_FRAME_SIZE-1-4k -: 4], with unwritten bits 0.
REQ-018 SHALL check nibbles 24..27 against 4'h0, 4'h8, 4'h0, 4'h0 (EtherType 0x0800); any mismatch SHALL set the type error and go to DROP in the same cycle.
REQ-019 SHALL, on mii_rx_err=1 sampled with mii_rx_dv=1 in PREAMBLE or RECEIVE, set the mii error and go to DROP.
REQ-020 SHALL set the len error and go to DROP on a nibble arriving when the count equals ETH_MAX_FRAME_SIZE/4.
REQ-021 SHALL set the len error and go to IDLE when mii_rx_dv falls in RECEIVE with an odd count or a count below 28.
REQ-022 SHALL, when mii_rx_dv falls in RECEIVE with an even count of at least 28, go to HOLD and assert rx_drv_rd_valid on the next cycle, with rx_drv_rd_len equal to the count.
REQ-023 SHALL hold rx_drv_rd_data and rx_drv_rd_len stable while rx_drv_rd_valid=1 and rx_drv_rd_ready=0.
REQ-024 SHALL complete a transfer on a cycle with valid=1 and ready=1; valid SHALL drop next cycle, then go to DROP if mii_rx_dv=1, else to IDLE.
REQ-025 SHALL, for a dv rising edge seen in HOLD, set the busy error and count one drop; that frame is never stored.
REQ-026 SHALL remain in DROP until mii_rx_dv=0, then go to IDLE.
REQ-027 SHALL increment rx_drop_count once per frame entering DROP from PREAMBLE or RECEIVE and once per frame rejected under REQ-021.
REQ-028 SHALL, when rx_err_clr and a new error occur in the same cycle, keep the new error bit set.

Reset
REQ-029 SHALL, while rst=0, force state IDLE, rx_drv_rd_valid=0, rx_drv_rd_data=0, rx_drv_rd_len=0, rx_err_status=0, rx_drop_count=0 and dv_q=1.
REQ-030 SHALL ignore a frame already in progress when reset is released, because dv_q=1 (REQ-014).

Verification
REQ-031 SHALL cover: 15x A, B, then 28 nibbles with nibbles 24..27 = 0,8,0,0, dv low, ready=1 -> valid 1 cycle after dv falls, len=28, data[255:144] matches the nibbles, error status 0.
REQ-032 SHALL cover: same frame with nibble 25 = 6 -> type bit set, drop_count=1, no valid, DROP until dv=0.
REQ-033 SHALL cover: mii_rx_err pulse at nibble 10 -> mii bit set, frame dropped; rx_err_clr pulse -> status 0.
REQ-034 SHALL cover: ready held 0 while a second frame arrives -> first frame data stays stable, busy bit set, drop_count=1, first frame delivered when ready=1.
REQ-035 SHALL cover: 65 nibbles after SFD (ETH_MAX_FRAME_SIZE=256) -> len bit set; and a 29-nibble frame -> len bit set, no valid.
REQ-036 SHALL cover: rst=0 for 1 cycle mid-RECEIVE -> all outputs 0; the rest of that frame is ignored; the next frame is received normally.

Source files
------------

// File: rtl/ether_rx_driver.sv
// MII receive driver: strips preamble/SFD, checks EtherType 0x0800 and frame length,
// and presents whole frames on a valid/ready port with sticky error and drop counters.
module ether_rx_driver #(
  parameter int unsigned ETH_MAX_FRAME_SIZE = 256
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [3:0]                            mii_rxd,
  input  logic                                  mii_rx_dv,
  input  logic                                  mii_rx_err,
  output logic [ETH_MAX_FRAME_SIZE-1:0]         rx_drv_rd_data,
  output logic [$clog2(ETH_MAX_FRAME_SIZE/4):0] rx_drv_rd_len,
  output logic                                  rx_drv_rd_valid,
  input  logic                                  rx_drv_rd_ready,
  output logic [4:0]                            rx_err_status,
  input  logic                                  rx_err_clr,
  output logic [7:0]                            rx_drop_count
);

  localparam int unsigned MAX_NIB  = ETH_MAX_FRAME_SIZE / 4;
  localparam int unsigned LEN_W    = $clog2(MAX_NIB) + 1;
  localparam int unsigned MIN_NIB  = 28;
  localparam int unsigned TYPE_LO  = 24;
  localparam int unsigned TYPE_HI  = 27;
  localparam int unsigned ERR_PRE  = 0;
  localparam int unsigned ERR_MII  = 1;
  localparam int unsigned ERR_TYPE = 2;
  localparam int unsigned ERR_LEN  = 3;
  localparam int unsigned ERR_BUSY = 4;
  localparam logic [3:0]  NIB_PRE  = 4'hA;
  localparam logic [3:0]  NIB_SFD  = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_RECEIVE, S_HOLD, S_DROP
  } state_t;

  state_t           state, state_next;
  logic             dv_q;
  logic [LEN_W-1:0] cnt;
  logic             rise, handshake, len_bad, type_bad, full;
  logic [3:0]       exp_nib;
  logic [4:0]       err_set;
  logic             drop_inc, nib_we, rx_start, hold_load;

  assign rise      = mii_rx_dv & ~dv_q;
  assign handshake = rx_drv_rd_valid & rx_drv_rd_ready;
  assign len_bad   = cnt[0] | (cnt < LEN_W'(MIN_NIB));
  assign full      = (cnt == LEN_W'(MAX_NIB));
  assign exp_nib   = (cnt == LEN_W'(TYPE_LO + 1)) ? 4'h8 : 4'h0;
  assign type_bad  = (cnt >= LEN_W'(TYPE_LO)) && (cnt <= LEN_W'(TYPE_HI)) && (mii_rxd != exp_nib);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:
        if (rise) state_next = (mii_rx_err || mii_rxd != NIB_PRE) ? S_DROP : S_PREAMBLE;
      S_PREAMBLE:
        if (!mii_rx_dv || mii_rx_err)  state_next = S_DROP;
        else if (mii_rxd == NIB_SFD)   state_next = S_RECEIVE;
        else if (mii_rxd != NIB_PRE)   state_next = S_DROP;
      S_RECEIVE:
        if (!mii_rx_dv)                          state_next = len_bad ? S_IDLE : S_HOLD;
        else if (mii_rx_err || full || type_bad) state_next = S_DROP;
      S_HOLD:
        if (handshake) state_next = mii_rx_dv ? S_DROP : S_IDLE;
      S_DROP:
        if (!mii_rx_dv) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Per-state actions: error flags, drop counting and datapath strobes
  always_comb begin
    err_set   = '0;
    drop_inc  = 1'b0;
    nib_we    = 1'b0;
    rx_start  = 1'b0;
    hold_load = 1'b0;
    unique case (state)
      S_IDLE:
        if (rise) begin
          if (mii_rx_err)             begin err_set[ERR_MII] = 1'b1; drop_inc = 1'b1; end
          else if (mii_rxd != NIB_PRE) begin err_set[ERR_PRE] = 1'b1; drop_inc = 1'b1; end
        end
      S_PREAMBLE:
        if (!mii_rx_dv)               begin err_set[ERR_PRE] = 1'b1; drop_inc = 1'b1; end
        else if (mii_rx_err)          begin err_set[ERR_MII] = 1'b1; drop_inc = 1'b1; end
        else if (mii_rxd == NIB_SFD)  rx_start = 1'b1;
        else if (mii_rxd != NIB_PRE)  begin err_set[ERR_PRE] = 1'b1; drop_inc = 1'b1; end
      S_RECEIVE:
        if (!mii_rx_dv) begin
          if (len_bad) begin err_set[ERR_LEN] = 1'b1; drop_inc = 1'b1; end
          else         hold_load = 1'b1;
        end
        else if (mii_rx_err) begin err_set[ERR_MII]  = 1'b1; drop_inc = 1'b1; end
        else if (full)       begin err_set[ERR_LEN]  = 1'b1; drop_inc = 1'b1; end
        else if (type_bad)   begin err_set[ERR_TYPE] = 1'b1; drop_inc = 1'b1; end
        else                 nib_we = 1'b1;
      S_HOLD:
        if (rise) begin err_set[ERR_BUSY] = 1'b1; drop_inc = 1'b1; end
      S_DROP: ;
      default: ;
    endcase
  end

  // Datapath and status registers; dv_q resets high so a frame already in flight is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q            <= 1'b1;
      cnt             <= '0;
      rx_drv_rd_data  <= '0;
      rx_drv_rd_len   <= '0;
      rx_drv_rd_valid <= 1'b0;
      rx_err_status   <= '0;
      rx_drop_count   <= '0;
    end else begin
      dv_q <= mii_rx_dv;
      if (rx_start)    cnt <= '0;
      else if (nib_we) cnt <= cnt + LEN_W'(1);
      if (rx_start) begin
        rx_drv_rd_data <= '0;
      end else begin
        for (int unsigned i = 0; i < MAX_NIB; i++)
          if (nib_we && cnt == LEN_W'(i))
            rx_drv_rd_data[ETH_MAX_FRAME_SIZE-1-4*i -: 4] <= mii_rxd;
      end
      if (hold_load) rx_drv_rd_len <= cnt;
      if (hold_load)      rx_drv_rd_valid <= 1'b1;
      else if (handshake) rx_drv_rd_valid <= 1'b0;
      rx_err_status <= (rx_err_status & {5{~rx_err_clr}}) | err_set;
      if (drop_inc && rx_drop_count != 8'hFF) rx_drop_count <= rx_drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ether_rx_driver.sv
// Directed bench for ether_rx_driver: table of whole-frame scenarios plus
// hand sequences for backpressure, drop-count saturation and mid-frame reset.
module tb_ether_rx_driver;

  localparam int unsigned W     = 256;
  localparam int unsigned LEN_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       mii_rxd;
  logic             mii_rx_dv, mii_rx_err;
  logic [W-1:0]     rx_drv_rd_data;
  logic [LEN_W-1:0] rx_drv_rd_len;
  logic             rx_drv_rd_valid, rx_drv_rd_ready;
  logic [4:0]       rx_err_status;
  logic             rx_err_clr;
  logic [7:0]       rx_drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;

  ether_rx_driver #(.ETH_MAX_FRAME_SIZE(W)) dut (
    .clk(clk), .rst(rst), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_err(mii_rx_err),
    .rx_drv_rd_data(rx_drv_rd_data), .rx_drv_rd_len(rx_drv_rd_len),
    .rx_drv_rd_valid(rx_drv_rd_valid), .rx_drv_rd_ready(rx_drv_rd_ready),
    .rx_err_status(rx_err_status), .rx_err_clr(rx_err_clr), .rx_drop_count(rx_drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               npre;
    int               n;
    int               err_at;
    logic [3:0]       n25;
    int               clr_at;
    logic             exp_valid;
    logic [LEN_W-1:0] exp_len;
    logic [4:0]       exp_status;
    int               exp_drops;
  } row_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input int k, input logic [3:0] n25, input int seed);
    case (k)
      24, 26, 27: return 4'h0;
      25:         return n25;
      default:    return 4'(k * 3 + seed);
    endcase
  endfunction

  function automatic logic [W-1:0] exp_data(input int n, input int seed);
    logic [W-1:0] d = '0;
    for (int k = 0; k < n; k++) d[W-1-4*k -: 4] = nib(k, 4'h8, seed);
    return d;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  task automatic drive(input logic [3:0] d, input logic e, input logic c);
    mii_rxd = d; mii_rx_dv = 1'b1; mii_rx_err = e; rx_err_clr = c;
    @(posedge clk); #1;
    mii_rx_err = 1'b0; rx_err_clr = 1'b0;
  endtask

  task automatic idle(input int cycles);
    mii_rx_dv = 1'b0; mii_rxd = 4'h0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  // Preamble, SFD, payload, then one cycle with dv low
  task automatic send_frame(input int npre, input int n, input int err_at,
                            input logic [3:0] n25, input int seed, input int clr_at);
    for (int i = 0; i < npre; i++) drive(4'hA, 1'b0, 1'b0);
    drive(4'hB, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) drive(nib(k, n25, seed), k == err_at, k == clr_at);
    idle(1);
  endtask

  row_t rows[11];

  initial begin
    rows[0]  = '{15, 28, -1, 4'h8, -1, 1'b1, 7'd28, 5'b00000, 0};
    rows[1]  = '{15, 28, -1, 4'h6, -1, 1'b0, 7'd0,  5'b00100, 1};
    rows[2]  = '{15, 28, 10, 4'h8, -1, 1'b0, 7'd0,  5'b00010, 1};
    rows[3]  = '{15, 29, -1, 4'h8, -1, 1'b0, 7'd0,  5'b01000, 1};
    rows[4]  = '{15, 65, -1, 4'h8, -1, 1'b0, 7'd0,  5'b01000, 1};
    rows[5]  = '{15, 64, -1, 4'h8, -1, 1'b1, 7'd64, 5'b00000, 0};
    rows[6]  = '{15, 26, -1, 4'h8, -1, 1'b0, 7'd0,  5'b01000, 1};
    rows[7]  = '{1,  40, -1, 4'h8, -1, 1'b1, 7'd40, 5'b00000, 0};
    rows[8]  = '{0,  28, -1, 4'h8, -1, 1'b0, 7'd0,  5'b00001, 1};
    rows[9]  = '{15, 28, -1, 4'h6, 25, 1'b0, 7'd0,  5'b00100, 1};
    rows[10] = '{7,  30, -1, 4'h8, -1, 1'b1, 7'd30, 5'b00000, 0};

    rst = 1'b0; mii_rxd = 4'h0; mii_rx_dv = 1'b0; mii_rx_err = 1'b0;
    rx_drv_rd_ready = 1'b1; rx_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", W'(rx_drv_rd_valid), '0);
    chk("reset_data", rx_drv_rd_data, '0);
    chk("reset_len", W'(rx_drv_rd_len), '0);
    chk("reset_status", W'(rx_err_status), '0);
    chk("reset_drop", W'(rx_drop_count), '0);
    rst = 1'b1;
    idle(2);

    foreach (rows[r]) begin
      send_frame(rows[r].npre, rows[r].n, rows[r].err_at, rows[r].n25, r + 1, rows[r].clr_at);
      exp_drop = sat_add(exp_drop, rows[r].exp_drops);
      chk($sformatf("row%0d_valid", r), W'(rx_drv_rd_valid), W'(rows[r].exp_valid));
      if (rows[r].exp_valid) begin
        chk($sformatf("row%0d_len", r), W'(rx_drv_rd_len), W'(rows[r].exp_len));
        chk($sformatf("row%0d_data", r), rx_drv_rd_data, exp_data(rows[r].n, r + 1));
      end
      chk($sformatf("row%0d_status", r), W'(rx_err_status), W'(rows[r].exp_status));
      chk($sformatf("row%0d_drop", r), W'(rx_drop_count), W'(exp_drop));
      idle(1);
      chk($sformatf("row%0d_valid_after", r), W'(rx_drv_rd_valid), '0);
      rx_err_clr = 1'b1; idle(1); rx_err_clr = 1'b0;
      chk($sformatf("row%0d_clr", r), W'(rx_err_status), '0);
      idle(2);
    end

    // Backpressure: second frame arrives while the first is still held
    rx_drv_rd_ready = 1'b0;
    send_frame(15, 28, -1, 4'h8, 20, -1);
    chk("bp_valid1", W'(rx_drv_rd_valid), W'(1));
    idle(2);
    chk("bp_hold_valid", W'(rx_drv_rd_valid), W'(1));
    chk("bp_hold_data", rx_drv_rd_data, exp_data(28, 20));
    send_frame(15, 30, -1, 4'h8, 21, -1);
    exp_drop = sat_add(exp_drop, 1);
    chk("bp_valid2", W'(rx_drv_rd_valid), W'(1));
    chk("bp_data", rx_drv_rd_data, exp_data(28, 20));
    chk("bp_len", W'(rx_drv_rd_len), W'(28));
    chk("bp_status", W'(rx_err_status), W'(5'b10000));
    chk("bp_drop", W'(rx_drop_count), W'(exp_drop));
    rx_drv_rd_ready = 1'b1;
    idle(1);
    chk("bp_valid_done", W'(rx_drv_rd_valid), '0);
    rx_err_clr = 1'b1; idle(1); rx_err_clr = 1'b0;
    idle(2);

    // Drop counter saturates: SFD as the very first nibble is a preamble error
    for (int i = 0; i < 260; i++) begin
      drive(4'hB, 1'b0, 1'b0);
      idle(1);
      exp_drop = sat_add(exp_drop, 1);
    end
    chk("sat_drop", W'(rx_drop_count), W'(exp_drop));
    chk("sat_status", W'(rx_err_status), W'(5'b00001));
    idle(2);

    // One-cycle reset in the middle of a frame
    for (int i = 0; i < 15; i++) drive(4'hA, 1'b0, 1'b0);
    drive(4'hB, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) drive(nib(k, 4'h8, 3), 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    exp_drop = 0;
    chk("midrst_valid", W'(rx_drv_rd_valid), '0);
    chk("midrst_data", rx_drv_rd_data, '0);
    chk("midrst_len", W'(rx_drv_rd_len), '0);
    chk("midrst_status", W'(rx_err_status), '0);
    chk("midrst_drop", W'(rx_drop_count), '0);
    mii_rxd = nib(10, 4'h8, 3); mii_rx_dv = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 11; k < 30; k++) drive(nib(k, 4'h8, 3), 1'b0, 1'b0);
    idle(1);
    chk("ignored_valid", W'(rx_drv_rd_valid), '0);
    chk("ignored_data", rx_drv_rd_data, '0);
    chk("ignored_status", W'(rx_err_status), '0);
    chk("ignored_drop", W'(rx_drop_count), W'(exp_drop));
    idle(2);
    send_frame(15, 28, -1, 4'h8, 9, -1);
    chk("post_rst_valid", W'(rx_drv_rd_valid), W'(1));
    chk("post_rst_len", W'(rx_drv_rd_len), W'(28));
    chk("post_rst_data", rx_drv_rd_data, exp_data(28, 9));
    chk("post_rst_status", W'(rx_err_status), '0);
    idle(1);
    chk("post_rst_valid_done", W'(rx_drv_rd_valid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
